// File: rtl/pwm_pattern_bank_if.sv
// Configuration, strobe and output bundle between the register mapper and the PWM pattern bank.
interface pwm_pattern_bank_if #(
  parameter int NUM_CH    = 4,
  parameter int PAT_WIDTH = 16,
  parameter int DUTY_W    = 8,
  parameter int GAP_W     = 16,
  parameter int CNT_W     = 8,
  parameter int DAC_WIDTH = 8
);
  logic                      cfg_wr;
  logic [$clog2(NUM_CH):0]   cfg_ch;
  logic [DUTY_W-1:0]         cfg_duty;
  logic [GAP_W-1:0]          cfg_gap;
  logic [CNT_W-1:0]          cfg_num;
  logic [PAT_WIDTH-1:0]      cfg_pat;
  logic [DAC_WIDTH-1:0]      cfg_dac;
  logic [NUM_CH-1:0]         ch_start;
  logic [NUM_CH-1:0]         ch_stop;
  logic [NUM_CH-1:0]         pwm_out;
  logic [NUM_CH-1:0]         busy;
  logic [NUM_CH-1:0]         valid;
  logic [DAC_WIDTH-1:0]      dac_data;

  modport master (
    output cfg_wr, cfg_ch, cfg_duty, cfg_gap, cfg_num, cfg_pat, cfg_dac, ch_start, ch_stop,
    input  pwm_out, busy, valid, dac_data
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_duty, cfg_gap, cfg_num, cfg_pat, cfg_dac, ch_start, ch_stop,
    output pwm_out, busy, valid, dac_data
  );
endinterface

// File: rtl/pwm_pattern_bank.sv
// Bank of independent pattern-PWM channels with double-buffered configuration;
// one channel additionally gates a DAC code onto dac_data.
module pwm_pattern_bank #(
  parameter int NUM_CH    = 4,
  parameter int PAT_WIDTH = 16,
  parameter int DUTY_W    = 8,
  parameter int GAP_W     = 16,
  parameter int CNT_W     = 8,
  parameter int DAC_WIDTH = 8,
  parameter int DAC_CH    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_pattern_bank_if.slave bus
);
  localparam int CHW = $clog2(NUM_CH) + 1;
  localparam int BW  = (PAT_WIDTH > 1) ? $clog2(PAT_WIDTH) : 1;
  localparam logic [BW-1:0] MSB = BW'(PAT_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PAT, GAP} state_t;

  logic [NUM_CH-1:0] pwm_v;
  logic [NUM_CH-1:0] busy_v;
  logic [NUM_CH-1:0] valid_v;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t               st_q, st_n;
    logic [DUTY_W-1:0]    sh_duty, a_duty, duty_eff;
    logic [GAP_W-1:0]     sh_gap, a_gap;
    logic [CNT_W-1:0]     sh_num, a_num;
    logic [PAT_WIDTH-1:0] sh_pat, a_pat, pat_src;
    logic [DUTY_W-1:0]    slot_q, slot_n;
    logic [BW-1:0]        bit_q, bit_n;
    logic [GAP_W-1:0]     gcnt_q, gcnt_n;
    logic [CNT_W-1:0]     burst_q, burst_n;
    logic                 load, valid_n, pwm_n, wr_hit;
    logic                 pwm_q, busy_q, valid_q;

    assign wr_hit   = bus.cfg_wr && (bus.cfg_ch == CHW'(g));
    assign duty_eff = (a_duty == '0) ? DUTY_W'(1) : a_duty;

    always_comb begin
      st_n    = st_q;
      slot_n  = slot_q;
      bit_n   = bit_q;
      gcnt_n  = gcnt_q;
      burst_n = burst_q;
      load    = 1'b0;
      valid_n = 1'b0;
      case (st_q)
        IDLE: begin
          if (bus.ch_start[g]) begin
            load    = 1'b1;
            st_n    = PAT;
            slot_n  = '0;
            bit_n   = MSB;
            burst_n = '0;
          end
        end
        PAT: begin
          if (slot_q == duty_eff - DUTY_W'(1)) begin
            slot_n = '0;
            if (bit_q != '0) begin
              bit_n = bit_q - BW'(1);
            end else begin
              // End of burst: either finish, insert a gap, or roll straight into the next MSB.
              burst_n = burst_q + CNT_W'(1);
              bit_n   = MSB;
              if (a_num != '0 && burst_n == a_num) begin
                st_n    = IDLE;
                valid_n = 1'b1;
              end else if (a_gap != '0) begin
                st_n   = GAP;
                gcnt_n = '0;
              end
            end
          end else begin
            slot_n = slot_q + DUTY_W'(1);
          end
        end
        GAP: begin
          if (gcnt_q + GAP_W'(1) == a_gap) begin
            st_n   = PAT;
            slot_n = '0;
            bit_n  = MSB;
          end else begin
            gcnt_n = gcnt_q + GAP_W'(1);
          end
        end
        default: st_n = IDLE;
      endcase
      if (bus.ch_stop[g]) begin
        st_n    = IDLE;
        load    = 1'b0;
        valid_n = 1'b0;
      end
      // On the start edge the pattern comes from the shadow copy being loaded.
      pat_src = load ? sh_pat : a_pat;
      pwm_n   = (st_n == PAT) && pat_src[bit_n];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st_q    <= IDLE;
        slot_q  <= '0;
        bit_q   <= '0;
        gcnt_q  <= '0;
        burst_q <= '0;
        sh_duty <= DUTY_W'(1);
        sh_gap  <= '0;
        sh_num  <= CNT_W'(1);
        sh_pat  <= '0;
        a_duty  <= DUTY_W'(1);
        a_gap   <= '0;
        a_num   <= CNT_W'(1);
        a_pat   <= '0;
        pwm_q   <= 1'b0;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        st_q    <= st_n;
        slot_q  <= slot_n;
        bit_q   <= bit_n;
        gcnt_q  <= gcnt_n;
        burst_q <= burst_n;
        if (load) begin
          a_duty <= sh_duty;
          a_gap  <= sh_gap;
          a_num  <= sh_num;
          a_pat  <= sh_pat;
        end
        if (wr_hit) begin
          sh_duty <= bus.cfg_duty;
          sh_gap  <= bus.cfg_gap;
          sh_num  <= bus.cfg_num;
          sh_pat  <= bus.cfg_pat;
        end
        pwm_q   <= pwm_n;
        busy_q  <= (st_n != IDLE);
        valid_q <= valid_n;
      end
    end

    assign pwm_v[g]   = pwm_q;
    assign busy_v[g]  = busy_q;
    assign valid_v[g] = valid_q;
  end

  assign bus.pwm_out = pwm_v;
  assign bus.busy    = busy_v;
  assign bus.valid   = valid_v;

  if (DAC_CH < NUM_CH) begin : g_dac
    logic [DAC_WIDTH-1:0] sh_dac, a_dac, dac_q;
    logic                 dac_load;

    // busy mirrors "not IDLE", so this matches the DAC channel's own load condition.
    assign dac_load = bus.ch_start[DAC_CH] && !bus.ch_stop[DAC_CH] && !busy_v[DAC_CH];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sh_dac <= '0;
        a_dac  <= '0;
        dac_q  <= '0;
      end else begin
        if (dac_load) a_dac <= sh_dac;
        if (bus.cfg_wr && bus.cfg_ch == CHW'(DAC_CH)) sh_dac <= bus.cfg_dac;
        dac_q <= pwm_v[DAC_CH] ? a_dac : '0;
      end
    end

    assign bus.dac_data = dac_q;
  end else begin : g_no_dac
    assign bus.dac_data = '0;
  end
endmodule

// File: tb/tb_pwm_pattern_bank.sv
// Randomised and directed bench for pwm_pattern_bank against a cycle-index waveform model.
module tb_pwm_pattern_bank;
  localparam int NCH = 4;
  localparam int PW  = 16;
  localparam int DCH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_pattern_bank_if #(.NUM_CH(NCH), .PAT_WIDTH(PW), .DUTY_W(8), .GAP_W(16), .CNT_W(8), .DAC_WIDTH(8)) bus ();

  pwm_pattern_bank #(.NUM_CH(NCH), .PAT_WIDTH(PW), .DUTY_W(8), .GAP_W(16), .CNT_W(8),
                     .DAC_WIDTH(8), .DAC_CH(DCH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  // Reference model: each running channel is described by its cycle index k since start.
  int unsigned sh_duty[NCH], sh_gap[NCH], sh_num[NCH], sh_pat[NCH];
  int unsigned a_duty[NCH], a_gap[NCH], a_num[NCH], a_pat[NCH];
  int unsigned sh_dac, a_dac;
  bit          run[NCH];
  int unsigned k[NCH];
  logic [NCH-1:0] exp_pwm = '0, exp_busy = '0, exp_valid = '0;
  logic [7:0]     exp_dac = '0;

  function automatic int unsigned eff_duty(int c);
    return (a_duty[c] == 0) ? 1 : a_duty[c];
  endfunction

  function automatic int unsigned run_len(int c);
    int unsigned d = eff_duty(c);
    return a_num[c] * PW * d + (a_num[c] - 1) * a_gap[c];
  endfunction

  function automatic bit wave(int c);
    int unsigned d = eff_duty(c);
    int unsigned plen = PW * d;
    int unsigned off = k[c] % (plen + a_gap[c]);
    if (off >= plen) return 1'b0;
    return bit'((a_pat[c] >> (PW - 1 - off / d)) & 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    exp_dac = (rst_n && exp_pwm[DCH]) ? 8'(a_dac) : 8'h00;
    for (int c = 0; c < NCH; c++) begin
      exp_valid[c] = 1'b0;
      if (!rst_n) begin
        run[c] = 0;
        sh_duty[c] = 1; sh_gap[c] = 0; sh_num[c] = 1; sh_pat[c] = 0;
      end else begin
        if (bus.ch_stop[c]) run[c] = 0;
        else if (run[c]) begin
          k[c]++;
          if (a_num[c] != 0 && k[c] == run_len(c)) begin
            run[c] = 0;
            exp_valid[c] = 1'b1;
          end
        end else if (bus.ch_start[c]) begin
          a_duty[c] = sh_duty[c]; a_gap[c] = sh_gap[c]; a_num[c] = sh_num[c]; a_pat[c] = sh_pat[c];
          if (c == DCH) a_dac = sh_dac;
          run[c] = 1;
          k[c] = 0;
        end
        if (bus.cfg_wr && int'(bus.cfg_ch) == c) begin
          sh_duty[c] = bus.cfg_duty; sh_gap[c] = bus.cfg_gap; sh_num[c] = bus.cfg_num; sh_pat[c] = bus.cfg_pat;
        end
      end
      exp_pwm[c]  = run[c] && wave(c);
      exp_busy[c] = run[c];
    end
    if (!rst_n) begin
      sh_dac = 0;
      a_dac = 0;
    end else if (bus.cfg_wr && int'(bus.cfg_ch) == DCH) sh_dac = bus.cfg_dac;
    #1;
  endtask

  task automatic set_cfg(int ch, int duty, int gap, int num, int pat, int dac);
    bus.cfg_wr = 1'b1;
    bus.cfg_ch = 3'(ch);
    bus.cfg_duty = 8'(duty);
    bus.cfg_gap = 16'(gap);
    bus.cfg_num = 8'(num);
    bus.cfg_pat = 16'(pat);
    bus.cfg_dac = 8'(dac);
  endtask

  task automatic write_cfg(int ch, int duty, int gap, int num, int pat, int dac);
    set_cfg(ch, duty, gap, num, pat, dac);
    tick();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({bus.pwm_out, bus.busy, bus.valid, bus.dac_data} !== 20'h0) begin
      bad++;
      $display("FAIL reset pwm=%b busy=%b valid=%b dac=%h, want all zero", bus.pwm_out, bus.busy, bus.valid, bus.dac_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_burst();
    int nb = 0, nv = 0, vat = 0;
    write_cfg(0, 2, 0, 1, 16'hA5A5, 0);
    bus.ch_start = 4'b0001;
    for (int i = 1; i <= 36; i++) begin
      tick();
      bus.ch_start = '0;
      total++;
      if ({bus.pwm_out, bus.busy, bus.valid, bus.dac_data} !== {exp_pwm, exp_busy, exp_valid, exp_dac}) begin
        bad++;
        $display("FAIL single_burst cyc=%0d pwm=%b want %b busy=%b want %b valid=%b want %b", i, bus.pwm_out, exp_pwm, bus.busy, exp_busy, bus.valid, exp_valid);
      end
      if (bus.busy[0]) nb++;
      if (bus.valid[0]) begin nv++; vat = i; end
    end
    total++;
    if (nb !== 32 || nv !== 1 || vat !== 33) begin
      bad++;
      $display("FAIL single_burst_timing busy=%0d valid_cnt=%0d valid_at=%0d, want 32/1/33", nb, nv, vat);
    end
  endtask

  task automatic test_repeat_gap();
    int nb = 0, nv = 0, first = -1, last = -1, nh = 0;
    write_cfg(1, 1, 5, 3, 16'h8000, 0);
    bus.ch_start = 4'b0010;
    for (int i = 1; i <= 62; i++) begin
      tick();
      bus.ch_start = '0;
      total++;
      if ({bus.pwm_out, bus.busy, bus.valid, bus.dac_data} !== {exp_pwm, exp_busy, exp_valid, exp_dac}) begin
        bad++;
        $display("FAIL repeat_gap cyc=%0d pwm=%b want %b busy=%b want %b valid=%b want %b", i, bus.pwm_out, exp_pwm, bus.busy, exp_busy, bus.valid, exp_valid);
      end
      if (bus.busy[1]) nb++;
      if (bus.valid[1]) nv++;
      if (bus.pwm_out[1]) begin
        nh++;
        if (first < 0) first = i;
        last = i;
      end
    end
    total++;
    if (nb !== 58 || nv !== 1 || nh !== 3 || last - first !== 42) begin
      bad++;
      $display("FAIL repeat_gap_timing busy=%0d valid=%0d highs=%0d span=%0d, want 58/1/3/42", nb, nv, nh, last - first);
    end
  endtask

  task automatic test_infinite_stop();
    int nv = 0;
    write_cfg(2, $urandom_range(1, 3), $urandom_range(0, 7), 0, $urandom_range(1, 16'hFFFF), 0);
    bus.ch_start = 4'b0100;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      bus.ch_start = '0;
      total++;
      if ({bus.pwm_out, bus.busy, bus.valid, bus.dac_data} !== {exp_pwm, exp_busy, exp_valid, exp_dac}) begin
        bad++;
        $display("FAIL infinite cyc=%0d pwm=%b want %b busy=%b want %b valid=%b want %b", i, bus.pwm_out, exp_pwm, bus.busy, exp_busy, bus.valid, exp_valid);
      end
      if (bus.valid[2]) nv++;
    end
    bus.ch_stop = 4'b0100;
    tick();
    bus.ch_stop = '0;
    total++;
    if (bus.busy[2] !== 1'b0 || bus.pwm_out[2] !== 1'b0 || bus.valid[2] !== 1'b0 || nv !== 0) begin
      bad++;
      $display("FAIL infinite_stop busy=%b pwm=%b valid=%b valid_cnt=%0d, want 0/0/0/0", bus.busy[2], bus.pwm_out[2], bus.valid[2], nv);
    end
  endtask

  task automatic test_double_buffer();
    int nh = 0, hat = 0;
    write_cfg(0, 1, 0, 1, 16'hFFFF, 0);
    bus.ch_start = 4'b0001;
    for (int i = 1; i <= 18; i++) begin
      if (i == 6) set_cfg(0, 1, 0, 1, 16'h0001, 0);
      tick();
      bus.ch_start = '0;
      bus.cfg_wr = 1'b0;
      total++;
      if ({bus.pwm_out, bus.busy, bus.valid, bus.dac_data} !== {exp_pwm, exp_busy, exp_valid, exp_dac}) begin
        bad++;
        $display("FAIL dbuf_midrun cyc=%0d pwm=%b want %b busy=%b want %b", i, bus.pwm_out, exp_pwm, bus.busy, exp_busy);
      end
      if (bus.pwm_out[0]) nh++;
    end
    total++;
    if (nh !== 16) begin
      bad++;
      $display("FAIL dbuf_midrun_highs got=%0d want 16", nh);
    end
    nh = 0;
    set_cfg(0, 1, 0, 1, 16'h8000, 0);
    bus.ch_start = 4'b0001;
    for (int i = 1; i <= 18; i++) begin
      tick();
      bus.ch_start = '0;
      bus.cfg_wr = 1'b0;
      total++;
      if ({bus.pwm_out, bus.busy, bus.valid, bus.dac_data} !== {exp_pwm, exp_busy, exp_valid, exp_dac}) begin
        bad++;
        $display("FAIL dbuf_same_cycle cyc=%0d pwm=%b want %b busy=%b want %b", i, bus.pwm_out, exp_pwm, bus.busy, exp_busy);
      end
      if (bus.pwm_out[0]) begin nh++; hat = i; end
    end
    total++;
    if (nh !== 1 || hat !== 16) begin
      bad++;
      $display("FAIL dbuf_same_cycle_pattern highs=%0d at=%0d, want 1 at 16", nh, hat);
    end
  endtask

  task automatic test_edge_cases();
    int nb = 0, nh = 0;
    write_cfg(1, 0, 0, 1, $urandom_range(0, 16'hFFFF), 0);
    bus.ch_start = 4'b0010;
    for (int i = 1; i <= 20; i++) begin
      if (i == 5) bus.ch_start = 4'b0010;
      tick();
      bus.ch_start = '0;
      total++;
      if ({bus.pwm_out, bus.busy, bus.valid, bus.dac_data} !== {exp_pwm, exp_busy, exp_valid, exp_dac}) begin
        bad++;
        $display("FAIL duty0 cyc=%0d pwm=%b want %b busy=%b want %b valid=%b want %b", i, bus.pwm_out, exp_pwm, bus.busy, exp_busy, bus.valid, exp_valid);
      end
      if (bus.busy[1]) nb++;
    end
    total++;
    if (nb !== 16) begin
      bad++;
      $display("FAIL duty0_len busy=%0d want 16", nb);
    end
    bus.ch_start = 4'b0100;
    bus.ch_stop = 4'b0100;
    tick();
    bus.ch_start = '0;
    bus.ch_stop = '0;
    total++;
    if (bus.busy[2] !== 1'b0 || bus.pwm_out[2] !== 1'b0) begin
      bad++;
      $display("FAIL start_stop busy=%b pwm=%b, want 0/0", bus.busy[2], bus.pwm_out[2]);
    end
    write_cfg(0, 1, 0, 1, 16'h0000, 0);
    write_cfg(4, 1, 0, 1, 16'hFFFF, 8'hAA);
    bus.ch_start = 4'b0001;
    for (int i = 1; i <= 18; i++) begin
      tick();
      bus.ch_start = '0;
      total++;
      if ({bus.pwm_out, bus.busy, bus.valid, bus.dac_data} !== {exp_pwm, exp_busy, exp_valid, exp_dac}) begin
        bad++;
        $display("FAIL bad_ch cyc=%0d pwm=%b want %b busy=%b want %b", i, bus.pwm_out, exp_pwm, bus.busy, exp_busy);
      end
      if (bus.pwm_out[0]) nh++;
    end
    total++;
    if (nh !== 0) begin
      bad++;
      $display("FAIL bad_ch_ignored highs=%0d want 0", nh);
    end
  endtask

  task automatic test_dac();
    int nd = 0, dfirst = 0, pfirst = 0;
    write_cfg(3, 1, 0, 1, 16'hF000, 8'hC3);
    bus.ch_start = 4'b1000;
    for (int i = 1; i <= 20; i++) begin
      tick();
      bus.ch_start = '0;
      total++;
      if ({bus.pwm_out, bus.busy, bus.valid, bus.dac_data} !== {exp_pwm, exp_busy, exp_valid, exp_dac}) begin
        bad++;
        $display("FAIL dac cyc=%0d pwm=%b want %b dac=%h want %h", i, bus.pwm_out, exp_pwm, bus.dac_data, exp_dac);
      end
      if (bus.pwm_out[3] && pfirst == 0) pfirst = i;
      if (bus.dac_data == 8'hC3) begin
        nd++;
        if (dfirst == 0) dfirst = i;
      end
    end
    total++;
    if (nd !== 4 || pfirst !== 1 || dfirst !== 2) begin
      bad++;
      $display("FAIL dac_timing count=%0d pwm_first=%0d dac_first=%0d, want 4/1/2", nd, pfirst, dfirst);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.cfg_wr = 1'b0;
      if ($urandom_range(0, 3) == 0)
        set_cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 16'hFFFF), $urandom_range(0, 255));
      bus.ch_start = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      bus.ch_stop  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      tick();
      total++;
      if ({bus.pwm_out, bus.busy, bus.valid, bus.dac_data} !== {exp_pwm, exp_busy, exp_valid, exp_dac}) begin
        bad++;
        $display("FAIL random cyc=%0d pwm=%b want %b busy=%b want %b valid=%b want %b dac=%h want %h", i, bus.pwm_out, exp_pwm, bus.busy, exp_busy, bus.valid, exp_valid, bus.dac_data, exp_dac);
      end
    end
    bus.cfg_wr = 1'b0;
    bus.ch_start = '0;
    bus.ch_stop = '0;
  endtask

  task automatic test_reset_midrun();
    for (int c = 0; c < NCH; c++) write_cfg(c, 1, 2, 0, 16'hFFFF, 8'h5A);
    bus.ch_start = 4'hF;
    tick();
    bus.ch_start = '0;
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    total++;
    if ({bus.pwm_out, bus.busy, bus.valid, bus.dac_data} !== 20'h0) begin
      bad++;
      $display("FAIL reset_midrun pwm=%b busy=%b valid=%b dac=%h, want all zero", bus.pwm_out, bus.busy, bus.valid, bus.dac_data);
    end
    rst_n = 1'b1;
    tick();
    bus.ch_start = 4'hF;
    for (int i = 1; i <= 18; i++) begin
      tick();
      bus.ch_start = '0;
      total++;
      if ({bus.pwm_out, bus.busy, bus.valid, bus.dac_data} !== {exp_pwm, exp_busy, exp_valid, exp_dac}) begin
        bad++;
        $display("FAIL shadow_reset cyc=%0d pwm=%b want %b busy=%b want %b valid=%b want %b", i, bus.pwm_out, exp_pwm, bus.busy, exp_busy, bus.valid, exp_valid);
      end
    end
  endtask

  initial begin
    bus.cfg_wr = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_duty = '0;
    bus.cfg_gap = '0;
    bus.cfg_num = '0;
    bus.cfg_pat = '0;
    bus.cfg_dac = '0;
    bus.ch_start = '0;
    bus.ch_stop = '0;
    test_reset();
    test_single_burst();
    test_repeat_gap();
    test_infinite_stop();
    test_double_buffer();
    test_edge_cases();
    test_dac();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
